// File: rtl/fim_gram_fifo_ctrl.sv
// rtl/fim_gram_fifo_ctrl.sv - FIFO controller sequencing an external fim_gram_sdp as storage
//
// Purpose: valid/ready push and pop interfaces over a simple dual-port RAM
// with RD_LAT read latency. A small flop prefetch buffer hides that latency
// so that one push and one pop per cycle are sustained.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_data     push interface
//   out_valid/out_ready/out_data  pop interface (out_data is the head word)
//   ram_we/ram_waddr/ram_din      RAM write port
//   ram_raddr/ram_dout            RAM read port (dout valid RD_LAT cycles after raddr)
//   count                         words held in RAM + in flight + prefetch buffer
module fim_gram_fifo_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_din,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [ADDR_W+1:0] count
);

  localparam int NB = RD_LAT + 1;
  localparam int BW = $clog2(NB + 1);

  generate
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $error("fim_gram_fifo_ctrl: RD_LAT must be 1 or 2");
    end
  endgenerate

  logic [ADDR_W:0]   wptr_q, wptr_d, rptr_q, rptr_d, wptr_vis_q, wptr_vis_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [DATA_W-1:0] buf_q [NB];
  logic [DATA_W-1:0] buf_d [NB];
  logic [BW-1:0]     buf_cnt_q, buf_cnt_d;
  logic [ADDR_W+1:0] count_q, count_d;
  logic              push, pop, issue, cap;
  logic [3:0]        inflight, credit;
  logic [BW-1:0]     cap_idx;

  always_comb begin
    // RAM full when pointers differ only in the wrap bit.
    in_ready  = ~rst & ((wptr_q[ADDR_W] == rptr_q[ADDR_W]) |
                        (wptr_q[ADDR_W-1:0] != rptr_q[ADDR_W-1:0]));
    out_valid = ~rst & (buf_cnt_q != '0);
    out_data  = buf_q[0];
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;

    ram_we    = push;
    ram_waddr = wptr_q[ADDR_W-1:0];
    ram_din   = in_data;
    ram_raddr = rptr_q[ADDR_W-1:0];
    count     = count_q;

    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + {3'b0, pipe_q[i]};

    // Credit: every issued read must have a buffer slot once it lands,
    // counting the slot freed by a pop in this same cycle.
    credit = inflight + 4'(buf_cnt_q) - {3'b0, pop};
    issue  = (wptr_vis_q != rptr_q) & (credit < 4'(NB));
    cap    = pipe_q[RD_LAT-1];

    wptr_d     = wptr_q + {{ADDR_W{1'b0}}, push};
    rptr_d     = rptr_q + {{ADDR_W{1'b0}}, issue};
    // Reads only target entries written at least two cycles ago.
    wptr_vis_d = wptr_q;

    pipe_d    = pipe_q;
    pipe_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];

    for (int i = 0; i < NB; i++) buf_d[i] = buf_q[i];
    if (pop) begin
      for (int i = 0; i < NB - 1; i++) buf_d[i] = buf_q[i+1];
    end
    // Capture lands behind the remaining entries, after any pop shift.
    cap_idx = buf_cnt_q - {{(BW-1){1'b0}}, pop};
    if (cap) buf_d[cap_idx] = ram_dout;
    buf_cnt_d = buf_cnt_q + {{(BW-1){1'b0}}, cap} - {{(BW-1){1'b0}}, pop};

    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      wptr_vis_q <= '0;
      pipe_q     <= '0;
      buf_cnt_q  <= '0;
      count_q    <= '0;
      for (int i = 0; i < NB; i++) buf_q[i] <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      wptr_vis_q <= wptr_vis_d;
      pipe_q     <= pipe_d;
      buf_cnt_q  <= buf_cnt_d;
      count_q    <= count_d;
      for (int i = 0; i < NB; i++) buf_q[i] <= buf_d[i];
    end
  end

endmodule
